// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, W-bit multiplexer with a manual select mode
// and an auto-scan mode, in which a dwell counter steps through the channels
// round-robin. It also drives an active-low one-hot channel enable and a
// strobe that pulses when the channel changes.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   en        update enable; low holds state and blanks onehot_n
//   auto      1 = auto-scan, 0 = manual select
//   sel_in    manual channel select (out-of-range values are held, not wrapped)
//   data_in   packed channels, channel k at [k*WIDTH +: WIDTH]
//   data_out  registered data of the selected channel
//   sel_out   registered current channel index
//   onehot_n  registered active-low one-hot of sel_out, all ones = blank
//   ch_strobe one-cycle pulse when sel_out changes
module scan_mux #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SEL_W    = 2,
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned DIV_W    = 17
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        auto,
   input  logic [SEL_W-1:0]            sel_in,
   input  logic [CHANNELS*WIDTH-1:0]   data_in,
   output logic [WIDTH-1:0]            data_out,
   output logic [SEL_W-1:0]            sel_out,
   output logic [CHANNELS-1:0]         onehot_n,
   output logic                        ch_strobe
);

   localparam int unsigned LAST_CH  = CHANNELS - 1;
   localparam int unsigned LAST_CNT = SCAN_DIV - 1;

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic [WIDTH-1:0] data_nxt;

   // Next channel and dwell count for an enabled edge.
   always_comb begin
      sel_nxt = sel_out;
      cnt_nxt = cnt;
      if (!auto) begin
         cnt_nxt = '0;
         if (32'(sel_in) < CHANNELS) begin
            sel_nxt = sel_in;
         end
      end else if (cnt == DIV_W'(LAST_CNT)) begin
         cnt_nxt = '0;
         sel_nxt = (sel_out == SEL_W'(LAST_CH)) ? '0 : sel_out + SEL_W'(1);
      end else begin
         cnt_nxt = cnt + DIV_W'(1);
      end
   end

   // Channel slice for the next select; sel_nxt is always in range.
   always_comb begin
      data_nxt = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (sel_nxt == SEL_W'(k)) begin
            data_nxt = data_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // Output and dwell registers; en low holds everything but blanks the enables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sel_out   <= '0;
         data_out  <= '0;
         onehot_n  <= '1;
         ch_strobe <= 1'b0;
      end else if (en) begin
         cnt       <= cnt_nxt;
         sel_out   <= sel_nxt;
         data_out  <= data_nxt;
         onehot_n  <= ~(CHANNELS'(1) << sel_nxt);
         ch_strobe <= (sel_nxt != sel_out);
      end else begin
         onehot_n  <= '1;
         ch_strobe <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: scoreboard bench for scan_mux. Three instances share stimulus:
//   u0: 4 channels, SCAN_DIV=4
//   u1: 3 channels, SCAN_DIV=4 (out-of-range select)
//   u2: 4 channels, SCAN_DIV=1 (advance on every enabled edge)
// A behavioural model pushes expected outputs before each edge; they are
// popped and compared one time unit after the edge.
module tb_scan_mux;

   typedef struct packed {
      logic [3:0] data;
      logic [1:0] sel;
      logic [3:0] oh;
      logic       strb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        auto;
   logic [1:0]  sel_in;
   logic [15:0] data_in;

   logic [3:0]  d0, d1, d2;
   logic [1:0]  s0, s1, s2;
   logic [3:0]  oh0, oh2;
   logic [2:0]  oh1;
   logic        st0, st1, st2;

   int checks   = 0;
   int failures = 0;

   exp_t exp_q[$];

   // model state per instance
   int         m_cnt [3];
   logic [1:0] m_sel [3];
   logic [3:0] m_data[3];
   logic [3:0] m_oh  [3];
   logic       m_strb[3];
   int         m_ch  [3] = '{4, 3, 4};
   int         m_div [3] = '{4, 4, 1};

   always #5 clk = ~clk;

   scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .SCAN_DIV(4), .DIV_W(2)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .sel_in(sel_in),
      .data_in(data_in), .data_out(d0), .sel_out(s0), .onehot_n(oh0), .ch_strobe(st0));

   scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .SCAN_DIV(4), .DIV_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .sel_in(sel_in),
      .data_in(data_in[11:0]), .data_out(d1), .sel_out(s1), .onehot_n(oh1), .ch_strobe(st1));

   scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .SCAN_DIV(1), .DIV_W(1)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .auto(auto), .sel_in(sel_in),
      .data_in(data_in), .data_out(d2), .sel_out(s2), .onehot_n(oh2), .ch_strobe(st2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [3:0] ch_mask(input int i);
      return 4'((1 << m_ch[i]) - 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         m_sel[i]  = 2'd0;
         m_data[i] = 4'd0;
         m_oh[i]   = ch_mask(i);
         m_strb[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      int ns;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         if (!en) begin
            m_oh[i]   = ch_mask(i);
            m_strb[i] = 1'b0;
            continue;
         end
         ns = int'(m_sel[i]);
         if (!auto) begin
            m_cnt[i] = 0;
            if (int'(sel_in) < m_ch[i]) ns = int'(sel_in);
         end else if (m_cnt[i] == m_div[i] - 1) begin
            m_cnt[i] = 0;
            ns = (ns == m_ch[i] - 1) ? 0 : ns + 1;
         end else begin
            m_cnt[i] = m_cnt[i] + 1;
         end
         m_data[i] = 4'(data_in >> (4 * ns));
         m_oh[i]   = ch_mask(i) & ~4'(1 << ns);
         m_strb[i] = (ns != int'(m_sel[i]));
         m_sel[i]  = 2'(ns);
      end
   endtask

   // one clock: push expectations, take the edge, pop and compare
   task automatic step();
      exp_t e;
      model_edge();
      for (int i = 0; i < 3; i++) exp_q.push_back('{m_data[i], m_sel[i], m_oh[i], m_strb[i]});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("u0.data", 32'(d0), 32'(e.data));
      check("u0.sel", 32'(s0), 32'(e.sel));
      check("u0.onehot_n", 32'(oh0), 32'(e.oh));
      check("u0.strobe", 32'(st0), 32'(e.strb));
      e = exp_q.pop_front();
      check("u1.data", 32'(d1), 32'(e.data));
      check("u1.sel", 32'(s1), 32'(e.sel));
      check("u1.onehot_n", 32'({1'b0, oh1}), 32'(e.oh));
      check("u1.strobe", 32'(st1), 32'(e.strb));
      e = exp_q.pop_front();
      check("u2.data", 32'(d2), 32'(e.data));
      check("u2.sel", 32'(s2), 32'(e.sel));
      check("u2.onehot_n", 32'(oh2), 32'(e.oh));
      check("u2.strobe", 32'(st2), 32'(e.strb));
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // hold reset across one edge, then release between edges
   task automatic do_reset(input logic a);
      rst_n = 1'b0;
      auto  = a;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      en      = 1'b1;
      auto    = 1'b0;
      sel_in  = 2'd0;
      data_in = 16'hD3A5;
      model_reset();
      steps(2);
      check("reset.data", 32'(d0), 32'h0);
      check("reset.sel", 32'(s0), 32'h0);
      check("reset.onehot_n", 32'(oh0), 32'hF);
      check("reset.onehot_n3", 32'(oh1), 32'h7);
      check("reset.strobe", 32'(st0), 32'h0);

      // manual select of channel 2
      sel_in = 2'd2;
      rst_n  = 1'b1;
      step();
      check("man.data", 32'(d0), 32'h3);
      check("man.sel", 32'(s0), 32'h2);
      check("man.onehot_n", 32'(oh0), 32'hB);
      check("man.strobe", 32'(st0), 32'h1);
      step();
      check("man.strobe_off", 32'(st0), 32'h0);

      // out-of-range select on the 3-channel instance
      sel_in = 2'd1;
      step();
      sel_in = 2'd3;
      steps(2);
      check("oor.sel", 32'(s1), 32'h1);
      check("oor.data", 32'(d1), 32'hA);
      check("oor.onehot_n", 32'(oh1), 32'h5);
      check("oor.strobe", 32'(st1), 32'h0);
      check("oor.sel4", 32'(s0), 32'h3);

      // auto scan from reset: 0 held, then 1,2,3,0 each for 4 edges
      do_reset(1'b1);
      for (int k = 1; k <= 20; k++) begin
         logic [15:0] dv;
         step();
         dv = 16'hD3A5;
         check("auto.sel", 32'(s0), 32'((k / 4) % 4));
         check("auto.data", 32'(d0), 32'(4'(dv >> (4 * ((k / 4) % 4)))));
         check("auto.strobe", 32'(st0), 32'((k % 4) == 0));
         check("div1.strobe", 32'(st2), 32'h1);
      end

      // enable gating with cnt=2 on channel 1
      do_reset(1'b1);
      steps(6);
      check("gate.pre_sel", 32'(s0), 32'h1);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("gate.onehot_n", 32'(oh0), 32'hF);
         check("gate.sel", 32'(s0), 32'h1);
      end
      en = 1'b1;
      step();
      check("gate.resume1", 32'(s0), 32'h1);
      step();
      check("gate.resume2", 32'(s0), 32'h2);
      check("gate.resume2_strobe", 32'(st0), 32'h1);

      // async reset mid-scan while on channel 3
      do_reset(1'b1);
      steps(12);
      check("areset.pre_sel", 32'(s0), 32'h3);
      #3;
      rst_n = 1'b0;
      #1;
      check("areset.data", 32'(d0), 32'h0);
      check("areset.sel", 32'(s0), 32'h0);
      check("areset.onehot_n", 32'(oh0), 32'hF);
      check("areset.strobe", 32'(st0), 32'h0);
      model_reset();
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("areset.dwell", 32'(s0), 32'(k == 4));
      end

      // mode switch: auto with cnt=2 on channel 2, then manual, then auto again
      do_reset(1'b1);
      steps(10);
      check("mode.pre_sel", 32'(s0), 32'h2);
      auto   = 1'b0;
      sel_in = 2'd0;
      step();
      check("mode.man_sel", 32'(s0), 32'h0);
      check("mode.man_strobe", 32'(st0), 32'h1);
      auto = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("mode.auto_dwell", 32'(s0), 32'(k == 4));
      end

      // randomised traffic against the model
      for (int k = 0; k < 300; k++) begin
         data_in = 16'($urandom);
         sel_in  = 2'($urandom_range(0, 3));
         en      = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) auto = ~auto;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // safety net against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
